// File: rtl/auto_charge_if.sv
// ---------------------------------------------------------------------------
// auto_charge_if
//   Configuration and status bundle of the auto charge sequencer.
//   master : slow-control side (drives the In_* settings, reads Out_* status)
//   slave  : the sequencer itself
//   Signals:
//     In_Start_Stop     run level (1 = run, 0 = stop)
//     In_Interval_Time  ticks between pulse starts (0 behaves as 1)
//     In_Pulse_Width    pulse high time in clock cycles (0 behaves as 1)
//     In_Burst_Count    pulses per run (0 = continuous)
//     In_Ch_Mask        enabled channels
//     In_Round_Robin    1 = one channel per pulse in rotation, 0 = all together
//     Out_Control_ADG   ADG switch controls
//     Out_Busy          sequencer counting or pulsing
//     Out_Done          one-cycle pulse at burst end
//     Out_Pulse_Cnt     pulses since last start, saturating
//   With AUTO_CHARGE_EXT_TRIG_EN defined two more inputs exist:
//     In_Ext_Trig       external trigger, already synchronous to the clock
//     In_Ext_Mode       1 = pulses fired by In_Ext_Trig instead of the timer
// ---------------------------------------------------------------------------
interface auto_charge_if #(
  parameter int N_CH       = 4,
  parameter int INTERVAL_W = 8,
  parameter int WIDTH_W    = 8,
  parameter int BURST_W    = 8
);

  logic                  In_Start_Stop;
  logic [INTERVAL_W-1:0] In_Interval_Time;
  logic [WIDTH_W-1:0]    In_Pulse_Width;
  logic [BURST_W-1:0]    In_Burst_Count;
  logic [N_CH-1:0]       In_Ch_Mask;
  logic                  In_Round_Robin;
  logic [N_CH-1:0]       Out_Control_ADG;
  logic                  Out_Busy;
  logic                  Out_Done;
  logic [15:0]           Out_Pulse_Cnt;

`ifdef AUTO_CHARGE_EXT_TRIG_EN
  logic                  In_Ext_Trig;
  logic                  In_Ext_Mode;

  modport master (
    output In_Start_Stop, In_Interval_Time, In_Pulse_Width, In_Burst_Count,
           In_Ch_Mask, In_Round_Robin, In_Ext_Trig, In_Ext_Mode,
    input  Out_Control_ADG, Out_Busy, Out_Done, Out_Pulse_Cnt
  );

  modport slave (
    input  In_Start_Stop, In_Interval_Time, In_Pulse_Width, In_Burst_Count,
           In_Ch_Mask, In_Round_Robin, In_Ext_Trig, In_Ext_Mode,
    output Out_Control_ADG, Out_Busy, Out_Done, Out_Pulse_Cnt
  );
`else
  modport master (
    output In_Start_Stop, In_Interval_Time, In_Pulse_Width, In_Burst_Count,
           In_Ch_Mask, In_Round_Robin,
    input  Out_Control_ADG, Out_Busy, Out_Done, Out_Pulse_Cnt
  );

  modport slave (
    input  In_Start_Stop, In_Interval_Time, In_Pulse_Width, In_Burst_Count,
           In_Ch_Mask, In_Round_Robin,
    output Out_Control_ADG, Out_Busy, Out_Done, Out_Pulse_Cnt
  );
`endif

endinterface

// File: rtl/auto_charge_sequencer.sv
// ---------------------------------------------------------------------------
// auto_charge_sequencer
//   Periodic multi-channel charge-injection generator driving the ADG
//   switches in front of the SKIROC test-charge inputs.
//   A run starts when In_Start_Stop is high with a non-empty mask; the
//   settings are captured at that moment and held for the whole run. Each
//   period is interval*TICK_DIV cycles of counting followed by width cycles
//   of pulse, so the period is exactly interval*TICK_DIV + width cycles.
//   Finite bursts end in DONE, which is left only when In_Start_Stop drops.
//
//   Ports:
//     Clk    system clock
//     Rst_N  synchronous active-low reset
//     bus    auto_charge_if.slave (settings in, ADG controls and status out)
//
//   Optional feature (macro AUTO_CHARGE_EXT_TRIG_EN): external trigger mode.
//   With In_Ext_Mode captured high at start, CNT ignores the interval timer
//   and moves to HIGH on the cycle after a registered rising edge of
//   In_Ext_Trig. Without the macro only the timed mode exists.
// ---------------------------------------------------------------------------
module auto_charge_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int N_CH       = 4,
  parameter int INTERVAL_W = 8,
  parameter int WIDTH_W    = 8,
  parameter int BURST_W    = 8
) (
  input  logic         Clk,
  input  logic         Rst_N,
  auto_charge_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CNT,
    S_HIGH,
    S_DONE
  } state_t;

  // Index of the lowest set bit; 0 for an empty mask.
  function automatic logic [PTR_W-1:0] lowest_set(input logic [N_CH-1:0] m);
    lowest_set = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = PTR_W'(i);
    end
  endfunction

  // Next set bit above p, wrapping round to the lowest; p itself when it is
  // the only set bit.
  function automatic logic [PTR_W-1:0] next_set(input logic [N_CH-1:0] m,
                                                input logic [PTR_W-1:0] p);
    logic found;
    int   idx;
    next_set = p;
    found    = 1'b0;
    for (int i = 1; i < N_CH; i++) begin
      idx = (int'(p) + i) % N_CH;
      if (!found && m[idx]) begin
        next_set = PTR_W'(idx);
        found    = 1'b1;
      end
    end
  endfunction

  state_t                state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [INTERVAL_W-1:0] ms_q, ms_d;
  logic [WIDTH_W-1:0]    wcnt_q, wcnt_d;
  logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [15:0]           pulse_cnt_q, pulse_cnt_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

  // Settings captured at start (already clamped).
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [WIDTH_W-1:0]    width_q, width_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [N_CH-1:0]       mask_q, mask_d;
  logic                  rr_mode_q, rr_mode_d;

  // Registered outputs.
  logic [N_CH-1:0]       ctrl_q, ctrl_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  timed_hit;
  logic                  fire;
  logic                  pulse_end;

`ifdef AUTO_CHARGE_EXT_TRIG_EN
  logic                  trig_q, trig_d;
  logic                  ext_edge_q, ext_edge_d;
  logic                  ext_mode_q, ext_mode_d;
`endif

  // Last cycle of the counting phase in timed mode.
  assign timed_hit = (tick_q == TICK_LAST) && (ms_q == interval_q - INTERVAL_W'(1));
  assign pulse_end = (wcnt_q == width_q - WIDTH_W'(1));

`ifdef AUTO_CHARGE_EXT_TRIG_EN
  assign fire = ext_mode_q ? ext_edge_q : timed_hit;
`else
  assign fire = timed_hit;
`endif

  always_comb begin
    // NOTE: every variable written here is given its default first, so no
    // branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    tick_d      = tick_q;
    ms_d        = ms_q;
    wcnt_d      = wcnt_q;
    burst_cnt_d = burst_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    interval_d  = interval_q;
    width_d     = width_q;
    burst_d     = burst_q;
    mask_d      = mask_q;
    rr_mode_d   = rr_mode_q;
`ifdef AUTO_CHARGE_EXT_TRIG_EN
    ext_mode_d  = ext_mode_q;
    trig_d      = bus.In_Ext_Trig;
    // Only edges seen while counting are kept; all others are dropped.
    ext_edge_d  = (state_q == S_CNT) && bus.In_Ext_Trig && !trig_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.In_Start_Stop && (bus.In_Ch_Mask != '0)) begin
          state_d     = S_CNT;
          interval_d  = (bus.In_Interval_Time == '0) ? INTERVAL_W'(1) : bus.In_Interval_Time;
          width_d     = (bus.In_Pulse_Width == '0) ? WIDTH_W'(1) : bus.In_Pulse_Width;
          burst_d     = bus.In_Burst_Count;
          mask_d      = bus.In_Ch_Mask;
          rr_mode_d   = bus.In_Round_Robin;
          rr_ptr_d    = lowest_set(bus.In_Ch_Mask);
          pulse_cnt_d = '0;
          burst_cnt_d = '0;
          tick_d      = '0;
          ms_d        = '0;
`ifdef AUTO_CHARGE_EXT_TRIG_EN
          ext_mode_d  = bus.In_Ext_Mode;
`endif
        end
      end

      S_CNT: begin
        if (!bus.In_Start_Stop) begin
          state_d = S_IDLE;
          tick_d  = '0;
          ms_d    = '0;
        end else if (fire) begin
          state_d = S_HIGH;
          tick_d  = '0;
          ms_d    = '0;
          wcnt_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          ms_d   = ms_q + INTERVAL_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      S_HIGH: begin
        // A stop request is only looked at once the pulse has completed.
        if (pulse_end) begin
          wcnt_d      = '0;
          pulse_cnt_d = (pulse_cnt_q == 16'hFFFF) ? pulse_cnt_q : pulse_cnt_q + 16'd1;
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
          rr_ptr_d    = next_set(mask_q, rr_ptr_q);
          if ((burst_q != '0) && (burst_cnt_q + BURST_W'(1) == burst_q)) begin
            state_d = S_DONE;
          end else if (!bus.In_Start_Stop) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_CNT;
          end
        end else begin
          wcnt_d = wcnt_q + WIDTH_W'(1);
        end
      end

      S_DONE: begin
        if (!bus.In_Start_Stop) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up exactly
    // with the state register.
    ctrl_d = '0;
    if (state_d == S_HIGH) begin
      ctrl_d = rr_mode_q ? (N_CH'(1) << rr_ptr_q) : mask_q;
    end
    busy_d = (state_d == S_CNT) || (state_d == S_HIGH);
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge Clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge.
    if (!Rst_N) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      ms_q        <= '0;
      wcnt_q      <= '0;
      burst_cnt_q <= '0;
      pulse_cnt_q <= '0;
      rr_ptr_q    <= '0;
      interval_q  <= '0;
      width_q     <= '0;
      burst_q     <= '0;
      mask_q      <= '0;
      rr_mode_q   <= 1'b0;
      ctrl_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef AUTO_CHARGE_EXT_TRIG_EN
      trig_q      <= 1'b0;
      ext_edge_q  <= 1'b0;
      ext_mode_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      ms_q        <= ms_d;
      wcnt_q      <= wcnt_d;
      burst_cnt_q <= burst_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      interval_q  <= interval_d;
      width_q     <= width_d;
      burst_q     <= burst_d;
      mask_q      <= mask_d;
      rr_mode_q   <= rr_mode_d;
      ctrl_q      <= ctrl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef AUTO_CHARGE_EXT_TRIG_EN
      trig_q      <= trig_d;
      ext_edge_q  <= ext_edge_d;
      ext_mode_q  <= ext_mode_d;
`endif
    end
  end

  assign bus.Out_Control_ADG = ctrl_q;
  assign bus.Out_Busy        = busy_q;
  assign bus.Out_Done        = done_q;
  assign bus.Out_Pulse_Cnt   = pulse_cnt_q;

endmodule

// File: tb/tb_auto_charge_sequencer.sv
// ---------------------------------------------------------------------------
// tb_auto_charge_sequencer
//   Directed stimulus with a scoreboard. The stimulus process pushes the
//   expected pulse / done events; a monitor watches Out_Control_ADG and
//   Out_Done on the falling clock edge, measures each pulse and pops the
//   matching expectation. TICK_DIV is shortened to 10.
//   Cycle bookkeeping: cyc counts rising edges. Inputs change on falling
//   edges; a start driven at cyc=c is sampled at the edge that makes
//   cyc=c+1, and the first pulse appears at cyc=c+interval*10+1.
// ---------------------------------------------------------------------------
module tb_auto_charge_sequencer;

  localparam int N_CH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  auto_charge_if #(.N_CH(N_CH), .INTERVAL_W(8), .WIDTH_W(8), .BURST_W(8)) bus ();

  auto_charge_sequencer #(
    .TICK_DIV(10), .N_CH(N_CH), .INTERVAL_W(8), .WIDTH_W(8), .BURST_W(8)
  ) dut (
    .Clk   (clk),
    .Rst_N (rst_n),
    .bus   (bus)
  );

  typedef enum int {EV_PULSE, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t        kind;
    logic [N_CH-1:0] ctrl;
    int              width;
    int              gap;         // cycles from reference to pulse rise
    bit              from_start;  // reference = start_mark, else previous rise
    int              cnt;         // Out_Pulse_Cnt after the event
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  start_mark = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input logic [N_CH-1:0] ctrl, input int width, input int gap,
                            input bit from_start, input int cnt);
    ev_t e;
    e.kind = EV_PULSE; e.ctrl = ctrl; e.width = width;
    e.gap = gap; e.from_start = from_start; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int cnt);
    ev_t e;
    e.kind = EV_DONE; e.ctrl = '0; e.width = 0;
    e.gap = 0; e.from_start = 1'b0; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic setup(input int iv, input int w, input int b,
                       input logic [N_CH-1:0] m, input bit rr);
    bus.In_Interval_Time = 8'(iv);
    bus.In_Pulse_Width   = 8'(w);
    bus.In_Burst_Count   = 8'(b);
    bus.In_Ch_Mask       = m;
    bus.In_Round_Robin   = rr;
  endtask

  task automatic start_run();
    bus.In_Start_Stop = 1'b1;
    start_mark = cyc;
  endtask

  // Monitor: measures every pulse and done event and compares it with the
  // oldest expectation.
  initial begin : monitor
    logic [N_CH-1:0] prev_ctrl;
    logic [N_CH-1:0] cur_ctrl;
    logic            prev_done;
    int              rise_cyc;
    int              last_rise;
    ev_t             e;
    prev_ctrl = '0; cur_ctrl = '0; prev_done = 1'b0;
    rise_cyc = 0; last_rise = 0;
    forever begin
      @(negedge clk);
      if (bus.Out_Control_ADG != '0 && prev_ctrl == '0) begin
        rise_cyc = cyc;
        cur_ctrl = bus.Out_Control_ADG;
      end
      if (bus.Out_Control_ADG == '0 && prev_ctrl != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", int'(e.kind), int'(EV_PULSE));
          check("pulse_ctrl", cur_ctrl, e.ctrl);
          check("pulse_width", cyc - rise_cyc, e.width);
          check("pulse_gap", rise_cyc - (e.from_start ? start_mark : last_rise), e.gap);
          check("pulse_cnt", bus.Out_Pulse_Cnt, e.cnt);
        end
        last_rise = rise_cyc;
      end
      if (prev_done) check("done_one_cycle", bus.Out_Done, 0);
      if (bus.Out_Done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", int'(e.kind), int'(EV_DONE));
          check("done_busy", bus.Out_Busy, 0);
          check("done_cnt", bus.Out_Pulse_Cnt, e.cnt);
        end
      end
      prev_ctrl = bus.Out_Control_ADG;
      prev_done = bus.Out_Done;
    end
  end

  initial begin : stimulus
    logic [N_CH-1:0] rr_seq [4];
    bus.In_Start_Stop = 1'b0;
`ifdef AUTO_CHARGE_EXT_TRIG_EN
    bus.In_Ext_Trig = 1'b0;
    bus.In_Ext_Mode = 1'b0;
`endif
    setup(0, 0, 0, '0, 1'b0);
    rst_n = 1'b0;
    idle(3);
    check("reset_ctrl", bus.Out_Control_ADG, 0);
    check("reset_busy", bus.Out_Busy, 0);
    check("reset_done", bus.Out_Done, 0);
    check("reset_cnt", bus.Out_Pulse_Cnt, 0);
    rst_n = 1'b1;
    idle(3);

    // 1) Simultaneous mode, continuous: first pulse 31 cycles after start,
    //    then every 35 cycles, 5 cycles wide.
    setup(3, 5, 0, 4'b0101, 1'b0);
    for (int k = 1; k <= 3; k++) push_pulse(4'b0101, 5, (k == 1) ? 31 : 35, k == 1, k);
    start_run();
    idle(20);
    check("busy_in_cnt", bus.Out_Busy, 1);
    idle(90);                      // third pulse ends at start+106
    bus.In_Start_Stop = 1'b0;      // stop in CNT before a fourth pulse
    idle(4);
    check("idle_busy", bus.Out_Busy, 0);
    check("idle_cnt_hold", bus.Out_Pulse_Cnt, 3);

    // 2) Round robin over mask 1011: 0,1,3,0. Settings changed mid-run
    //    must be ignored.
    setup(3, 5, 0, 4'b1011, 1'b1);
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;
    for (int k = 0; k < 4; k++) push_pulse(rr_seq[k], 5, (k == 0) ? 31 : 35, k == 0, k + 1);
    start_run();
    idle(5);
    setup(1, 2, 1, 4'b1111, 1'b0);
    idle(140);                     // fourth pulse ends at start+141
    bus.In_Start_Stop = 1'b0;
    idle(4);

    // 3) Burst of 3 (interval 1, width 2, period 12), done, then a new
    //    burst only after start goes low and high again.
    setup(1, 2, 3, 4'b0101, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 3; k++) push_pulse(4'b0101, 2, (k == 1) ? 11 : 12, k == 1, k);
      push_done(3);
      start_run();
      idle(70);                    // done at start+37, nothing after
      check("done_state_busy", bus.Out_Busy, 0);
      check("done_state_cnt", bus.Out_Pulse_Cnt, 3);
      bus.In_Start_Stop = 1'b0;
      idle(5);
    end

    // 4a) Stop on the second HIGH cycle: the pulse still lasts 5 cycles.
    setup(3, 5, 0, 4'b0010, 1'b0);
    push_pulse(4'b0010, 5, 31, 1'b1, 1);
    start_run();
    idle(32);
    bus.In_Start_Stop = 1'b0;
    idle(50);
    check("stop_high_busy", bus.Out_Busy, 0);
    check("stop_high_cnt", bus.Out_Pulse_Cnt, 1);

    // 4b) Stop mid-CNT: no pulse, idle on the next cycle.
    start_run();
    idle(15);
    check("mid_cnt_busy", bus.Out_Busy, 1);
    bus.In_Start_Stop = 1'b0;
    idle(1);
    check("stop_cnt_busy", bus.Out_Busy, 0);
    check("stop_cnt_cnt", bus.Out_Pulse_Cnt, 0);
    idle(40);

    // 5) Interval 0 / width 0 clamp to 1/1: 1-cycle pulse every 11 cycles.
    //    Single-bit mask in round robin behaves like simultaneous mode.
    setup(0, 0, 0, 4'b1000, 1'b1);
    for (int k = 1; k <= 3; k++) push_pulse(4'b1000, 1, 11, k == 1, k);
    start_run();
    idle(36);                      // third pulse ends at start+34
    bus.In_Start_Stop = 1'b0;
    idle(3);

    // 5b) Empty mask with start high: stays idle.
    setup(1, 1, 0, 4'b0000, 1'b0);
    bus.In_Start_Stop = 1'b1;
    idle(20);
    check("empty_mask_busy", bus.Out_Busy, 0);
    check("empty_mask_ctrl", bus.Out_Control_ADG, 0);
    check("empty_mask_cnt", bus.Out_Pulse_Cnt, 3);
    bus.In_Start_Stop = 1'b0;
    idle(3);

    // 6) Reset for one cycle in the middle of a pulse.
    setup(1, 5, 0, 4'b1111, 1'b0);
    push_pulse(4'b1111, 3, 11, 1'b1, 0);
    start_run();
    idle(13);
    rst_n = 1'b0;
    bus.In_Start_Stop = 1'b0;
    idle(1);
    check("rst_mid_ctrl", bus.Out_Control_ADG, 0);
    check("rst_mid_busy", bus.Out_Busy, 0);
    check("rst_mid_done", bus.Out_Done, 0);
    check("rst_mid_cnt", bus.Out_Pulse_Cnt, 0);
    rst_n = 1'b1;
    idle(20);
    check("rst_after_busy", bus.Out_Busy, 0);

`ifdef AUTO_CHARGE_EXT_TRIG_EN
    // 7) External trigger: pulse starts 2 cycles after the trigger edge.
    setup(1, 2, 0, 4'b0001, 1'b0);
    bus.In_Ext_Mode = 1'b1;
    bus.In_Start_Stop = 1'b1;
    idle(30);
    push_pulse(4'b0001, 2, 2, 1'b1, 1);
    bus.In_Ext_Trig = 1'b1;
    start_mark = cyc;
    idle(1);
    bus.In_Ext_Trig = 1'b0;
    idle(10);
    bus.In_Start_Stop = 1'b0;
    bus.In_Ext_Mode = 1'b0;
    idle(5);
`endif

    idle(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
